// File: rtl/minirv_pkg.sv
// Shared types for the miniRV data-memory stage: memory op codes, LSU FSM
// states and small op-classification helpers.
package minirv_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        LW  = 2'd0,
        LBU = 2'd1,
        SW  = 2'd2,
        SB  = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } lsu_state_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == SW) || (op == SB);
    endfunction

    // Only the full-word ops care about alignment; byte ops fit any offset.
    function automatic logic is_word_op(input mem_op_e op);
        return (op == LW) || (op == SW);
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational byte-lane steering: store strobes and data replication,
// plus byte selection and zero extension for LBU loads.
module byte_lane_align
    import minirv_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_ext_o
);

    always_comb begin
        wstrb_o     = 4'b0000;
        wdata_rep_o = wdata_i;
        rdata_ext_o = rdata_i;
        case (op_i)
            SW: begin
                wstrb_o = 4'b1111;
            end
            // Replicating the byte lets memory pick it up on whichever lane is strobed.
            SB: begin
                wstrb_o     = 4'b0001 << offset_i;
                wdata_rep_o = {WORD_BYTES{wdata_i[7:0]}};
            end
            LBU: begin
                rdata_ext_o = {24'h000000, rdata_i[{offset_i, 3'b000} +: 8]};
            end
            default: begin
                rdata_ext_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// miniRV load/store unit: one core request in, one word-addressed memory
// access with grant/rvalid timeouts, one response out. Optional MISALIGN_TRAP_EN.
module load_store_unit
    import minirv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e        state_q, state_d;
    mem_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              misalign;
    logic              timeoutHit;
    logic [3:0]        laneStrb;
    logic [31:0]       laneWdata;
    logic [31:0]       laneRdata;

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_word_op(mem_op_e'(req_op)) && (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign timeoutHit = (cnt_q == CNT_LAST);

    byte_lane_align u_align (
        .op_i        (op_q),
        .offset_i    (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_i     (dmem_rdata),
        .wstrb_o     (laneStrb),
        .wdata_rep_o (laneWdata),
        .rdata_ext_o (laneRdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Progress (gnt/rvalid) is tested before expiry so it wins on the last cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = mem_op_e'(req_op);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = misalign;
                    state_d = misalign ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (dmem_gnt) begin
                    cnt_d   = '0;
                    state_d = is_store(op_q) ? DONE : WAIT_R;
                end else if (timeoutHit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid) begin
                    rdata_d = laneRdata;
                    state_d = DONE;
                end else if (timeoutHit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory-side outputs are only non-zero while a request is being offered.
    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        resp_valid = (state_q == DONE);
        resp_err   = (state_q == DONE) && err_q;
        resp_rdata = (state_q == DONE) ? rdata_q : '0;
        dmem_req   = (state_q == ISSUE);
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = 4'b0000;
        if (state_q == ISSUE) begin
            dmem_we    = is_store(op_q);
            dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            dmem_wdata = laneWdata;
            dmem_wstrb = laneStrb;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions against a per-transaction timing/formatting model.
module tb_load_store_unit;

    localparam int T = 4;
    localparam logic [1:0] OP_LW  = 2'd0;
    localparam logic [1:0] OP_LBU = 2'd1;
    localparam logic [1:0] OP_SW  = 2'd2;
    localparam logic [1:0] OP_SB  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYC (T),
        .ADDR_W      (32),
        .DATA_W      (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .busy        (busy),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One full transaction, entered and left at a falling edge with the DUT idle.
    // g = ISSUE cycles before gnt, rv = WAIT_R cycles before rvalid.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int g, input int rv, input logic [31:0] memWord);
        logic        isStore;
        logic        trap;
        logic [1:0]  off;
        logic [3:0]  expStrb;
        logic [31:0] expWdata;
        logic [31:0] expAddr;
        logic [31:0] expRdata;
        logic        expErr;
        int          respCyc;
        int          issueEnd;

        isStore = op[1];
        off     = addr[1:0];
`ifdef MISALIGN_TRAP_EN
        trap = ((op == OP_LW) || (op == OP_SW)) && (off != 2'b00);
`else
        trap = 1'b0;
`endif
        expAddr  = addr & 32'hFFFF_FFFC;
        expStrb  = (op == OP_SW) ? 4'hF : (op == OP_SB) ? (4'b0001 << off) : 4'h0;
        expWdata = (op == OP_SB) ? {4{wdata[7:0]}} : wdata;
        expRdata = 32'h0;
        expErr   = 1'b0;
        if (trap) begin
            respCyc = 1; issueEnd = 0; expErr = 1'b1;
        end else if (g >= T) begin
            respCyc = T + 1; issueEnd = T; expErr = 1'b1;
        end else if (isStore) begin
            respCyc = g + 2; issueEnd = g + 1;
        end else if (rv >= T) begin
            respCyc = g + T + 2; issueEnd = g + 1; expErr = 1'b1;
        end else begin
            respCyc = g + rv + 3; issueEnd = g + 1;
            expRdata = (op == OP_LW) ? memWord : ((memWord >> (8 * off)) & 32'hFF);
        end

        checkOutput("readyBeforeReq", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;

        for (int k = 1; k <= respCyc; k++) begin
            @(negedge clk);
            checkOutput("dmemReq", {31'b0, dmem_req}, {31'b0, k <= issueEnd});
            if (k <= issueEnd) begin
                checkOutput("dmemAddr", dmem_addr, expAddr);
                checkOutput("dmemWstrb", {28'b0, dmem_wstrb}, {28'b0, expStrb});
                checkOutput("dmemWe", {31'b0, dmem_we}, {31'b0, isStore});
                if (isStore) checkOutput("dmemWdata", dmem_wdata, expWdata);
            end
            checkOutput("respValid", {31'b0, resp_valid}, {31'b0, k == respCyc});
            checkOutput("busy", {31'b0, busy}, 32'd1);
            checkOutput("readyWhileBusy", {31'b0, req_ready}, 32'd0);
            if (k == respCyc) begin
                checkOutput("respErr", {31'b0, resp_err}, {31'b0, expErr});
                checkOutput("respRdata", resp_rdata, expRdata);
            end
            dmem_gnt    = (!trap && g < T && k == g + 1) || (k > issueEnd && $urandom_range(0, 3) == 0);
            dmem_rvalid = !trap && !isStore && g < T && rv < T && k == g + 2 + rv;
            dmem_rdata  = dmem_rvalid ? memWord : $urandom;
        end
        @(negedge clk);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        checkOutput("readyAfterDone", {31'b0, req_ready}, 32'd1);
        checkOutput("respValidAfter", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'd0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstReady", {31'b0, req_ready}, 32'd1);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstRespValid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rstDmemReq", {31'b0, dmem_req}, 32'd0);
        checkOutput("rstDmemAddr", dmem_addr, 32'h0);
        checkOutput("rstDmemWstrb", {28'b0, dmem_wstrb}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        applyStimulus(OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 2, 0, 32'h0);
        applyStimulus(OP_SB,  32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0);
        applyStimulus(OP_LBU, 32'h0000_0102, 32'h0,         0, 0, 32'h1122_3344);
        applyStimulus(OP_LW,  32'h0000_0104, 32'h0,         1, 2, 32'hCAFE_F00D);
        applyStimulus(OP_SW,  32'h0000_0300, 32'h1234_5678, 10, 0, 32'h0);
        applyStimulus(OP_LW,  32'h0000_0308, 32'h0,         T - 1, T - 1, 32'h5555_AAAA);
        applyStimulus(OP_LBU, 32'h0000_0401, 32'h0,         0, T + 2, 32'h8899_AABB);
        applyStimulus(OP_LW,  32'h0000_0101, 32'h0,         0, 0, 32'h0BAD_CAFE);
        applyStimulus(OP_SW,  32'h0000_0502, 32'h7777_8888, 0, 0, 32'h0);

        // Reset pulsed while a load waits for read data; the late rvalid must be dropped.
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0108; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        checkOutput("waitBusy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midRstReady", {31'b0, req_ready}, 32'd1);
        checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFEED_FACE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            checkOutput("lateRvalidResp", {31'b0, resp_valid}, 32'd0);
            checkOutput("lateRvalidReady", {31'b0, req_ready}, 32'd1);
        end

        for (int n = 0; n < 300; n++) begin
            applyStimulus(2'($urandom), $urandom, $urandom,
                          ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1),
                          ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, T - 1),
                          $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
